// File: rtl/spi_burst_pkg.sv
// Shared types and helpers for the SPI burst slave controller.
// Provides FSM state encoding, command frame length and RW bit position.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_LOAD,
    ST_XFER_R,
    ST_XFER_W
  } state_e;

  // RW is the first bit on the wire, so it ends up as the command MSB
  localparam bit RW_READ = 1'b1;

  function automatic int cmd_len(input int addr_w);
    return 1 + addr_w;
  endfunction

  function automatic int rw_pos(input int addr_w);
    return cmd_len(addr_w) - 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses.
// Ports: i_clk, i_rst (sync, active high), i_d -> o_rise, o_fall.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // Reset to 0: a pin already low after reset never yields a fall pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/spi_burst_slave_ctrl.sv
// SPI mode-0 slave for burst register-file reads/writes with auto-increment.
// Ports: SPI pins (sck/cs_n/mosi/miso/oe), reg-file strobes, o_busy.
// Optional write path: define SPI_BURST_WRITE_EN.
module spi_burst_slave_ctrl
  import spi_burst_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_reg_re,
  input  logic [DATA_W-1:0] i_reg_rdata,
  output logic              o_reg_we,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_busy
);

  localparam int CLEN = cmd_len(ADDR_W);
  localparam int MAXL = (CLEN > DATA_W) ? CLEN : DATA_W;
  localparam int CW   = $clog2(MAXL) + 1;

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_sck),
    .o_rise (sck_rise),
    .o_fall (sck_fall)
  );

  // cs_n falls when the frame starts, rises when it ends
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_cs_n),
    .o_rise (cs_rise),
    .o_fall (cs_fall)
  );

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CLEN-2:0]     cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
`ifdef SPI_BURST_WRITE_EN
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                we_q, we_d;
`endif

  logic            mosi;
  logic [CLEN-1:0] full;
  logic            last_cmd, last_word;

  // MOSI is one stage behind the sck pulse, still inside its half-period
  assign mosi      = mosi_q[SYNC_STAGES-1];
  assign full      = {cmd_q, mosi};
  assign last_cmd  = cnt_q == CW'(CLEN - 1);
  assign last_word = cnt_q == CW'(DATA_W - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      mosi_q  <= '0;
`ifdef SPI_BURST_WRITE_EN
      rx_q    <= '0;
      we_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      mosi_q  <= mosi_d;
`ifdef SPI_BURST_WRITE_EN
      rx_q    <= rx_d;
      we_q    <= we_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && last_cmd) begin
            if (full[rw_pos(ADDR_W)] == RW_READ)
              state_d = ST_FETCH;
            else
`ifdef SPI_BURST_WRITE_EN
              state_d = ST_XFER_W;
`else
              // busy stays set, so IDLE acts as a wait for cs_n rise
              state_d = ST_IDLE;
`endif
          end
        end
        ST_FETCH:  state_d = ST_LOAD;
        ST_LOAD:   state_d = ST_XFER_R;
        ST_XFER_R: if (sck_rise && last_word) state_d = ST_FETCH;
`ifdef SPI_BURST_WRITE_EN
        ST_XFER_W: state_d = ST_XFER_W;
`endif
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    cmd_d  = cmd_q;
    addr_d = addr_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    mosi_d = {mosi_q[SYNC_STAGES-2:0], i_mosi};
`ifdef SPI_BURST_WRITE_EN
    rx_d   = rx_q;
    we_d   = 1'b0;
    if (we_q) addr_d = addr_q + ADDR_W'(1);
`endif
    if (cs_rise) busy_d = 1'b0;
    else if (cs_fall && state_q == ST_IDLE) busy_d = 1'b1;

    if (cs_rise) begin
      cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: cnt_d = '0;
        ST_CMD: begin
          if (sck_rise) begin
            cmd_d = full[CLEN-2:0];
            if (last_cmd) begin
              cnt_d  = '0;
              addr_d = full[ADDR_W-1:0];
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_LOAD: begin
          tx_d  = i_reg_rdata;
          cnt_d = '0;
        end
        ST_XFER_R: begin
          if (sck_rise) begin
            if (last_word) begin
              cnt_d  = '0;
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (sck_fall && cnt_q != '0) begin
            // fall before the word's first rise keeps the MSB on the pin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
`ifdef SPI_BURST_WRITE_EN
        ST_XFER_W: begin
          if (sck_rise) begin
            rx_d = {rx_q[DATA_W-2:0], mosi};
            if (last_word) begin
              cnt_d = '0;
              we_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    o_reg_re    = state_q == ST_FETCH;
    o_miso_oe   = (state_q == ST_XFER_R) && !cs_rise;
    o_miso      = o_miso_oe & tx_q[DATA_W-1];
    o_reg_addr  = addr_q;
    o_busy      = busy_q;
`ifdef SPI_BURST_WRITE_EN
    o_reg_we    = we_q;
    o_reg_wdata = rx_q;
`else
    o_reg_we    = 1'b0;
    o_reg_wdata = '0;
`endif
  end

endmodule
